lfsr_seed_serializer: RTL and testbench

//  Transmit end of the LFSR seed-injection interface. Takes a parallel seed word

---
 rtl/lfsr_seed_serializer_if.sv | 11 +
 rtl/lfsr_seed_serializer.sv | 132 +++++++++++++
 tb/tb_lfsr_seed_serializer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_seed_serializer_if.sv
// Seed handshake bundle between the key/config register block and the seed serializer.
interface lfsr_seed_serializer_if #(
   parameter int unsigned SEED_W = 22
);
   logic [SEED_W-1:0] seed_data;
   logic              seed_valid;
   logic              seed_ready;

   modport master (output seed_data, output seed_valid, input seed_ready);
   modport slave  (input seed_data, input seed_valid, output seed_ready);
endinterface

// File: rtl/lfsr_seed_serializer.sv
// Serialises a parallel seed MSB-first into a serial-in LFSR as shift_bit/trigger
// strobes, optionally followed by zero-bit warm-up pulses.
module lfsr_seed_serializer #(
   parameter int unsigned SEED_W = 22,
   parameter int unsigned WARMUP = 0,
   parameter int unsigned GAP    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   lfsr_seed_serializer_if.slave seed,
   input  logic                  abort,
   output logic                  shift_bit,
   output logic                  trigger,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned N_PULSE = SEED_W + WARMUP;
   localparam int unsigned CNT_W   = $clog2(N_PULSE + 1);
   localparam int unsigned GAP_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t            state, state_d;
   logic [SEED_W-1:0] sreg, sreg_d;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
   logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
   logic              shift_d, trig_d, busy_d, done_d, ready_d;
   logic              ready_q;
   logic              accept;

   assign seed.seed_ready = ready_q;

   // State, shift register, counters and all outputs are flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         sreg      <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         shift_bit <= 1'b0;
         trigger   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state     <= state_d;
         sreg      <= sreg_d;
         bit_cnt   <= bit_cnt_d;
         gap_cnt   <= gap_cnt_d;
         shift_bit <= shift_d;
         trigger   <= trig_d;
         busy      <= busy_d;
         done      <= done_d;
         ready_q   <= ready_d;
      end
   end

   // Outputs follow the current state one cycle later, so the data bit is set up
   // a full cycle before the strobe rises and held through it.
   always_comb begin
      state_d   = state;
      sreg_d    = sreg;
      bit_cnt_d = bit_cnt;
      gap_cnt_d = gap_cnt;
      shift_d   = shift_bit;
      trig_d    = 1'b0;
      done_d    = 1'b0;
      accept    = 1'b0;

      if ((state != ST_IDLE) && abort) begin
         state_d   = ST_IDLE;
         sreg_d    = '0;
         bit_cnt_d = '0;
         gap_cnt_d = '0;
         shift_d   = 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               shift_d = 1'b0;
               if (seed.seed_valid && ready_q && !abort) begin
                  accept    = 1'b1;
                  state_d   = ST_SETUP;
                  sreg_d    = seed.seed_data;
                  bit_cnt_d = '0;
                  gap_cnt_d = '0;
               end
            end
            ST_SETUP: begin
               state_d = ST_PULSE;
               shift_d = sreg[SEED_W-1];
            end
            ST_PULSE: begin
               trig_d    = 1'b1;
               // Zeros shifted in at the bottom become the warm-up bits.
               sreg_d    = {sreg[SEED_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt + CNT_W'(1);
               gap_cnt_d = '0;
               if (GAP != 0)
                  state_d = ST_GAP;
               else if (bit_cnt == CNT_W'(N_PULSE - 1))
                  state_d = ST_DONE;
               else
                  state_d = ST_SETUP;
            end
            ST_GAP: begin
               if (gap_cnt == GAP_W'(GAP - 1))
                  state_d = (bit_cnt == CNT_W'(N_PULSE)) ? ST_DONE : ST_SETUP;
               else
                  gap_cnt_d = gap_cnt + GAP_W'(1);
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               shift_d = 1'b0;
               done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Ready comes back one cycle after the machine returns to IDLE, i.e. after done.
      ready_d = (state == ST_IDLE) && !accept;
      busy_d  = !ready_d;
   end

endmodule

// File: tb/tb_lfsr_seed_serializer.sv
// Scoreboard bench: stimulus queues expected pulse bits, latencies and LFSR states;
// a negedge monitor pops and compares as the two serializer instances emit pulses.
module tb_lfsr_seed_serializer;

   localparam int unsigned SW = 22;
   localparam int GAP0  = 1;
   localparam int WARM0 = 0;
   localparam int GAP1  = 0;
   localparam int WARM1 = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [1:0] abort = 2'b00;
   logic trig0, trig1, sbit0, sbit1, busy0, busy1, done0, done1;
   logic [1:0] trig_v, sbit_v, busy_v, done_v, ready_v, valid_v;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic        exp_bits [2][$];
   int          exp_lat  [2][$];
   logic [21:0] exp_lfsr [2][$];

   int          hs_edge   [2];
   int          last_trig [2];
   bit          first     [2];
   logic        prev_sb   [2];
   logic [21:0] mdl       [2];

   lfsr_seed_serializer_if #(.SEED_W(SW)) if0 ();
   lfsr_seed_serializer_if #(.SEED_W(SW)) if1 ();

   lfsr_seed_serializer #(.SEED_W(SW), .WARMUP(WARM0), .GAP(GAP0)) dut0 (
      .clk(clk), .reset_n(reset_n), .seed(if0.slave), .abort(abort[0]),
      .shift_bit(sbit0), .trigger(trig0), .busy(busy0), .done(done0));

   lfsr_seed_serializer #(.SEED_W(SW), .WARMUP(WARM1), .GAP(GAP1)) dut1 (
      .clk(clk), .reset_n(reset_n), .seed(if1.slave), .abort(abort[1]),
      .shift_bit(sbit1), .trigger(trig1), .busy(busy1), .done(done1));

   assign trig_v  = {trig1, trig0};
   assign sbit_v  = {sbit1, sbit0};
   assign busy_v  = {busy1, busy0};
   assign done_v  = {done1, done0};
   assign ready_v = {if1.seed_ready, if0.seed_ready};
   assign valid_v = {if1.seed_valid, if0.seed_valid};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [21:0] lfsr_step(input logic [21:0] s, input logic b);
      return {s[20:0], s[21] ^ s[20] ^ b};
   endfunction

   function automatic logic [21:0] ref_lfsr(input logic [21:0] data, input int warm);
      logic [21:0] s;
      s = '0;
      for (int i = SW - 1; i >= 0; i--) s = lfsr_step(s, data[i]);
      for (int i = 0; i < warm; i++) s = lfsr_step(s, 1'b0);
      return s;
   endfunction

   task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc %0d got %0h expected %0h", nm, d, cyc, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic [21:0] data);
      if (d == 0) begin
         if0.seed_valid = v;
         if0.seed_data  = data;
      end else begin
         if1.seed_valid = v;
         if1.seed_data  = data;
      end
   endtask

   // Monitor step for one instance; runs on the falling edge.
   task automatic mon_step(input int d);
      logic e;
      int gap;
      gap = (d == 0) ? GAP0 : GAP1;
      if (trig_v[d]) begin
         if (exp_bits[d].size() == 0) begin
            chk(d, "unexpected_trigger", 32'(trig_v[d]), 32'd0);
         end else begin
            e = exp_bits[d].pop_front();
            chk(d, "pulse_bit", 32'(sbit_v[d]), 32'(e));
            chk(d, "pulse_period", cyc - last_trig[d], first[d] ? 2 : 2 + gap);
            chk(d, "bit_setup_stable", 32'(sbit_v[d]), 32'(prev_sb[d]));
         end
         mdl[d] = lfsr_step(mdl[d], sbit_v[d]);
         last_trig[d] = cyc;
         first[d] = 1'b0;
      end
      if (done_v[d]) begin
         if (exp_lat[d].size() == 0) begin
            chk(d, "unexpected_done", 32'(done_v[d]), 32'd0);
         end else begin
            chk(d, "done_latency", cyc - hs_edge[d], exp_lat[d].pop_front());
            chk(d, "lfsr_state", 32'(mdl[d]), 32'(exp_lfsr[d].pop_front()));
            chk(d, "bits_at_done", exp_bits[d].size(), 0);
            chk(d, "done_shift_bit", 32'(sbit_v[d]), 32'd0);
         end
      end
      if (valid_v[d] && ready_v[d] && !abort[d]) begin
         hs_edge[d]   = cyc + 1;
         last_trig[d] = cyc + 1;
         mdl[d]       = '0;
         first[d]     = 1'b1;
      end
      prev_sb[d] = sbit_v[d];
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         for (int d = 0; d < 2; d++) mon_step(d);
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic send(input int d, input logic [21:0] data, input int n_bits, input bit with_done);
      int waited;
      int warm;
      int gap;
      waited = 0;
      warm = (d == 0) ? WARM0 : WARM1;
      gap  = (d == 0) ? GAP0 : GAP1;
      for (int i = 0; i < int'(SW) + warm && i < n_bits; i++)
         exp_bits[d].push_back((i < int'(SW)) ? data[SW-1-i] : 1'b0);
      if (with_done) begin
         exp_lat[d].push_back(1 + (int'(SW) + warm) * (2 + gap));
         exp_lfsr[d].push_back(ref_lfsr(data, warm));
      end
      while (ready_v[d] !== 1'b1 && waited < 500) begin
         @(posedge clk);
         #1;
         waited++;
      end
      chk(d, "ready_wait_bound", 32'(waited < 500), 32'd1);
      drive(d, 1'b1, data);
      @(posedge clk);
      #1;
      drive(d, 1'b0, '0);
   endtask

   task automatic wait_idle(input int d);
      int waited;
      waited = 0;
      while (ready_v[d] !== 1'b1 && waited < 500) begin
         @(posedge clk);
         #1;
         waited++;
      end
      chk(d, "idle_wait_bound", 32'(waited < 500), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc %0d got no finish expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      drive(0, 1'b1, 22'h155555);
      drive(1, 1'b1, 22'h2AAAAA);

      // Reset held with seed_valid high: nothing moves, not ready.
      repeat (3) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            chk(d, "rst_trigger", 32'(trig_v[d]), 32'd0);
            chk(d, "rst_shift_bit", 32'(sbit_v[d]), 32'd0);
            chk(d, "rst_ready", 32'(ready_v[d]), 32'd0);
         end
      end
      reset_n = 1'b1;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk(d, "post_rst_ready", 32'(ready_v[d]), 32'd1);
         chk(d, "post_rst_busy", 32'(busy_v[d]), 32'd0);
      end

      // Full seeds on both instances, overlapping in time.
      send(0, 22'h2AAAAA, 99, 1'b1);
      chk(0, "ready_drop", 32'(ready_v[0]), 32'd0);
      chk(0, "busy_rise", 32'(busy_v[0]), 32'd1);
      send(1, 22'h3C0F5A, 99, 1'b1);
      wait_idle(0);
      wait_idle(1);
      send(0, 22'h155555, 99, 1'b1);
      send(1, 22'h000001, 99, 1'b1);
      wait_idle(0);
      wait_idle(1);
      send(0, 22'h3FFFFF, 99, 1'b1);
      send(1, 22'h3FFFFF, 99, 1'b1);
      wait_idle(0);
      wait_idle(1);

      // Abort during the 5th trigger pulse.
      send(0, 22'h2D3C81, 5, 1'b0);
      repeat (14) @(posedge clk);
      #1;
      chk(0, "fifth_pulse_high", 32'(trig_v[0]), 32'd1);
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      chk(0, "abort_trigger", 32'(trig_v[0]), 32'd0);
      chk(0, "abort_shift_bit", 32'(sbit_v[0]), 32'd0);
      @(posedge clk);
      #1;
      chk(0, "abort_ready", 32'(ready_v[0]), 32'd1);
      chk(0, "abort_no_done", 32'(done_v[0]), 32'd0);
      send(0, 22'h0F0F0F, 99, 1'b1);
      wait_idle(0);

      // Abort in IDLE is ignored; abort blocks a simultaneous handshake.
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      chk(0, "idle_abort_ready", 32'(ready_v[0]), 32'd1);
      chk(0, "idle_abort_busy", 32'(busy_v[0]), 32'd0);
      drive(0, 1'b1, 22'h123456);
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      drive(0, 1'b0, '0);
      abort[0] = 1'b0;
      chk(0, "abort_blocks_hs_ready", 32'(ready_v[0]), 32'd1);
      chk(0, "abort_blocks_hs_busy", 32'(busy_v[0]), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk(0, "abort_blocks_hs_idle", 32'(busy_v[0]), 32'd0);

      // Async reset in the trigger-low gap after the first pulse.
      send(0, 22'h3FFFFF, 1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk(0, "pre_rst_shift_bit", 32'(sbit_v[0]), 32'd1);
      reset_n = 1'b0;
      #1;
      chk(0, "midrst_trigger", 32'(trig_v[0]), 32'd0);
      chk(0, "midrst_shift_bit", 32'(sbit_v[0]), 32'd0);
      chk(0, "midrst_busy", 32'(busy_v[0]), 32'd0);
      chk(0, "midrst_ready", 32'(ready_v[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk(d, "post_midrst_ready", 32'(ready_v[d]), 32'd1);
         chk(d, "post_midrst_busy", 32'(busy_v[d]), 32'd0);
      end

      send(0, 22'h2AAAAA, 99, 1'b1);
      send(1, 22'h155555, 99, 1'b1);
      wait_idle(0);
      wait_idle(1);
      repeat (3) @(posedge clk);
      #1;

      for (int d = 0; d < 2; d++) begin
         chk(d, "bits_left", exp_bits[d].size(), 0);
         chk(d, "lat_left", exp_lat[d].size(), 0);
         chk(d, "lfsr_left", exp_lfsr[d].size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
